rtype_exec_sequencer: RTL and testbench
=======================================

Name: rtype_exec_sequencer

Overview:
- Multi-cycle controller that sequences the R-type datapath: fetches a word from instruction memory, decodes it, drives the ALU and register file controls, and stalls for the multi-cycle multiplier.
- Sits between instruction memory, the register file, the ALU and the MUL unit.
- Replaces single-cycle control for builds where MUL is iterative.
- ALU encodings: AND 0000, OR 0001, ADD 0010, SLL 0011, SUB 0100, SRL 0101, MUL 0110, XOR 0111.

Parameters:
PC_WIDTH, 32, width of program counter and imem address
RESET_PC, 0, address of the first fetch after start
PC_STEP, 4, PC increment per retired instruction

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin execution at RESET_PC; accepted only in IDLE or TRAP
halt_req  input  1  stop after the current instruction retires
imem_req  output  1  fetch request
imem_addr  output  PC_WIDTH  fetch address (current PC)
imem_valid  input  1  imem_rdata valid this cycle
imem_rdata  input  32  instruction word
rs1_addr  output  5  instr[19:15]
rs2_addr  output  5  instr[24:20]
rd_addr  output  5  instr[11:7]
alu_control  output  4  ALU operation select
mul_start  output  1  one-cycle pulse that launches the multiplier
mul_done  input  1  multiplier result ready
regwrite_control  output  1  one-cycle register-file write enable
busy  output  1  high in every state except IDLE and TRAP
illegal_instr  output  1  sticky illegal-instruction flag
retired_count  output  32  count of retired instructions, wraps modulo 2^32

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, PC=RESET_PC, IR=0.
  - All outputs are 0; imem_addr=RESET_PC.
  - retired_count=0, halt latch cleared.
  - Reset mid-operation abandons the instruction with no write or pulse.
- States: IDLE, FETCH, DECODE, EXEC, MUL_WAIT, WB, TRAP.
- IDLE:
  - start=1 loads PC=RESET_PC and moves to FETCH.
  - start does not clear retired_count; only reset does.
- FETCH:
  - imem_req=1 and imem_addr=PC until imem_valid=1.
  - imem_valid may arrive in the first FETCH cycle.
  - On valid: IR<=imem_rdata, go to DECODE.
  - imem_valid outside FETCH is ignored.
- DECODE (1 cycle):
  - Register rs1/rs2/rd addresses and alu_control from IR; they hold through WB.
  - Legal instruction requires opcode=0110011 plus one of:
    - funct3=0 with funct7=0 (ADD) or funct7=32 (SUB);
    - funct3 in {1,2,4,5,6,7} with funct7=0, giving SLL, MUL, XOR, SRL, OR, AND respectively.
  - Anything else is illegal, including funct3=3 and funct3=5 with funct7=32. Illegal goes to TRAP.
  - Otherwise go to EXEC.
- EXEC (1 cycle):
  - Non-MUL: go to WB.
  - MUL: mul_start=1 for this cycle only, then go to MUL_WAIT.
- MUL_WAIT:
  - Wait until mul_done=1, then go to WB.
  - mul_done is sampled only in MUL_WAIT; a done during EXEC is ignored.
  - There is no timeout.
- WB (1 cycle):
  - regwrite_control=1 unless rd_addr=0, in which case it stays 0 but the instruction still retires.
  - PC<=PC+PC_STEP, wrapping at PC_WIDTH.
  - retired_count<=retired_count+1.
  - Next state: IDLE if the halt latch is set (latch clears), else FETCH.
- halt_req:
  - Latched on any cycle while busy.
  - Seen in IDLE, it is ignored.
  - It never aborts an in-flight instruction.
- TRAP:
  - illegal_instr=1, busy=0, PC holds the offending address, no regwrite.
  - The halt latch clears on entry.
  - start clears illegal_instr, loads RESET_PC and goes to FETCH.
- start while busy is ignored.
- Latency with zero-wait imem: non-MUL instruction takes 4 cycles (FETCH, DECODE, EXEC, WB); MUL takes 4+N, where N is the number of MUL_WAIT cycles.
- regwrite_control and mul_start never assert in the same cycle.

Test Plan:
- ADD stream: reset, start, imem always valid, returns 0x002081B3 (add x3,x1,x2) -> imem_addr 0,4,8 on successive FETCHes; alu_control=0010, rd_addr=3; regwrite pulse every 4th cycle; retired_count increments.
- SUB/XOR decode: 0x40208133 -> alu_control=0100, rs1=1, rs2=2, rd=2; 0x0020C1B3 -> alu_control=0111.
- MUL stall: 0x0020A1B3, mul_done raised 5 cycles after mul_start -> mul_start exactly one cycle; regwrite exactly one cycle, one cycle after mul_done; no FETCH before it.
- Illegal instructions:
  - 0x0020B1B3 (funct3=3) -> TRAP, illegal_instr=1, busy=0, PC=fault address, no regwrite.
  - 0x4020D1B3 (SRA) -> TRAP as well.
  - start from TRAP -> flag clears, fetch at 0.
- Halt and rd=0: halt_req pulsed during DECODE -> instruction completes WB, returns to IDLE, imem_req=0. Instruction with rd=0 -> retired_count increments, regwrite stays 0.
- Reset mid-MUL_WAIT: assert reset -> state IDLE immediately (asynchronous), all outputs 0, retired_count=0; a late mul_done causes no regwrite.

Source files
------------

// File: rtl/rtype_exec_sequencer.sv
// Multi-cycle R-type controller: fetch, decode, ALU/regfile control, and
// a stall state that waits on an iterative multiplier.
module rtype_exec_sequencer #(
  parameter int unsigned          PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
  parameter int unsigned          PC_STEP  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                halt_req,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_valid,
  input  logic [31:0]         imem_rdata,
  output logic [4:0]          rs1_addr,
  output logic [4:0]          rs2_addr,
  output logic [4:0]          rd_addr,
  output logic [3:0]          alu_control,
  output logic                mul_start,
  input  logic                mul_done,
  output logic                regwrite_control,
  output logic                busy,
  output logic                illegal_instr,
  output logic [31:0]         retired_count
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_DECODE   = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;
  localparam logic [2:0] S_MUL_WAIT = 3'd4;
  localparam logic [2:0] S_WB       = 3'd5;
  localparam logic [2:0] S_TRAP     = 3'd6;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_MUL = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;

  logic [2:0]          r_state;
  logic [2:0]          w_next;
  logic [31:0]         r_ir;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_halt;
  logic [31:0]         r_retired;
  logic [4:0]          r_rs1;
  logic [4:0]          r_rs2;
  logic [4:0]          r_rd;
  logic [3:0]          r_alu;
  logic                r_imem_req;
  logic                r_mul_start;
  logic                r_regwrite;
  logic                r_busy;
  logic                r_illegal;

  logic [2:0]          w_funct3;
  logic [6:0]          w_funct7;
  logic                w_legal;
  logic                w_is_mul;
  logic [3:0]          w_alu;
  logic                w_busy_state;
  logic                w_next_busy;

  assign w_funct3     = r_ir[14:12];
  assign w_funct7     = r_ir[31:25];
  assign w_busy_state = (r_state != S_IDLE) && (r_state != S_TRAP);
  assign w_next_busy  = (w_next != S_IDLE) && (w_next != S_TRAP);
  assign w_is_mul     = w_legal && (w_alu == ALU_MUL);

  // Instruction decode from the held IR; only funct7=32 variant accepted is SUB.
  always_comb begin
    w_legal = 1'b0;
    w_alu   = ALU_AND;
    if (r_ir[6:0] == OPC_RTYPE) begin
      case (w_funct3)
        3'd0: begin
          if (w_funct7 == 7'd0) begin
            w_legal = 1'b1;
            w_alu   = ALU_ADD;
          end else if (w_funct7 == 7'd32) begin
            w_legal = 1'b1;
            w_alu   = ALU_SUB;
          end
        end
        3'd1: begin w_legal = (w_funct7 == 7'd0); w_alu = ALU_SLL; end
        3'd2: begin w_legal = (w_funct7 == 7'd0); w_alu = ALU_MUL; end
        3'd4: begin w_legal = (w_funct7 == 7'd0); w_alu = ALU_XOR; end
        3'd5: begin w_legal = (w_funct7 == 7'd0); w_alu = ALU_SRL; end
        3'd6: begin w_legal = (w_funct7 == 7'd0); w_alu = ALU_OR;  end
        3'd7: begin w_legal = (w_funct7 == 7'd0); w_alu = ALU_AND; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = S_FETCH;
      S_FETCH:    if (imem_valid) w_next = S_DECODE;
      S_DECODE:   w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC:     w_next = w_is_mul ? S_MUL_WAIT : S_WB;
      S_MUL_WAIT: if (mul_done) w_next = S_WB;
      S_WB:       w_next = (r_halt || halt_req) ? S_IDLE : S_FETCH;
      S_TRAP:     if (start) w_next = S_FETCH;
      default:    w_next = S_IDLE;
    endcase
  end

  // Datapath registers; outputs are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_ir        <= 32'd0;
      r_halt      <= 1'b0;
      r_retired   <= 32'd0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_rd        <= 5'd0;
      r_alu       <= 4'd0;
      r_imem_req  <= 1'b0;
      r_mul_start <= 1'b0;
      r_regwrite  <= 1'b0;
      r_busy      <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      if (((r_state == S_IDLE) || (r_state == S_TRAP)) && start)
        r_pc <= RESET_PC;
      else if (r_state == S_WB)
        r_pc <= r_pc + PC_WIDTH'(PC_STEP);

      if ((r_state == S_FETCH) && imem_valid)
        r_ir <= imem_rdata;

      if (r_state == S_DECODE) begin
        r_rs1 <= r_ir[19:15];
        r_rs2 <= r_ir[24:20];
        r_rd  <= r_ir[11:7];
        r_alu <= w_alu;
      end

      if (r_state == S_WB)
        r_retired <= r_retired + 32'd1;

      if ((r_state == S_WB) || (w_next == S_TRAP))
        r_halt <= 1'b0;
      else if (w_busy_state && halt_req)
        r_halt <= 1'b1;

      r_imem_req  <= (w_next == S_FETCH);
      r_busy      <= w_next_busy;
      r_mul_start <= (w_next == S_EXEC) && w_is_mul;
      r_regwrite  <= (w_next == S_WB) && (r_ir[11:7] != 5'd0);

      if (w_next == S_TRAP)
        r_illegal <= 1'b1;
      else if ((r_state == S_TRAP) && start)
        r_illegal <= 1'b0;
    end
  end

  assign imem_req         = r_imem_req;
  assign imem_addr        = r_pc;
  assign rs1_addr         = r_rs1;
  assign rs2_addr         = r_rs2;
  assign rd_addr          = r_rd;
  assign alu_control      = r_alu;
  assign mul_start        = r_mul_start;
  assign regwrite_control = r_regwrite;
  assign busy             = r_busy;
  assign illegal_instr    = r_illegal;
  assign retired_count    = r_retired;

endmodule

// File: tb/tb_rtype_exec_sequencer.sv
// Randomized self-checking bench for rtype_exec_sequencer with an
// instruction-level reference model (decode table, PC and retire counters).
module tb_rtype_exec_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        halt_req;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [3:0]  alu_control;
  logic        mul_start;
  logic        mul_done;
  logic        regwrite_control;
  logic        busy;
  logic        illegal_instr;
  logic [31:0] retired_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_retired;

  typedef struct {
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] alu;
  } op_t;
  op_t ops[8];

  always #5 clock = ~clock;

  rtype_exec_sequencer #(.PC_WIDTH(32), .RESET_PC(32'd0), .PC_STEP(4)) dut (
    .clock(clock), .reset(reset), .start(start), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .alu_control(alu_control), .mul_start(mul_start),
    .mul_done(mul_done), .regwrite_control(regwrite_control), .busy(busy),
    .illegal_instr(illegal_instr), .retired_count(retired_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference decode: search the table of legal (funct3, funct7) pairs.
  function automatic void ref_decode(input logic [31:0] w, output bit legal,
                                     output bit is_mul, output logic [3:0] alu);
    legal = 1'b0;
    alu   = 4'd0;
    if (w[6:0] == 7'h33) begin
      foreach (ops[i]) begin
        if (ops[i].f3 == w[14:12] && ops[i].f7 == w[31:25]) begin
          legal = 1'b1;
          alu   = ops[i].alu;
        end
      end
    end
    is_mul = legal && (alu == 4'b0110);
  endfunction

  // Runs one instruction starting at a negedge inside FETCH. halt_sel<0 means
  // no halt pulse; otherwise it picks a cycle between FETCH and WB.
  task automatic run_instr(input logic [31:0] word, input int imem_wait,
                           input int mul_wait, input int halt_sel, input bit spur);
    bit         legal, is_mul, halted;
    logic [3:0] alu;
    int         wb_c, c, k, rw_cnt, rw_at, ms_cnt, ms_at, halt_cyc;
    ref_decode(word, legal, is_mul, alu);
    wb_c     = is_mul ? 3 + mul_wait : 3;
    halt_cyc = (halt_sel < 0) ? -1 : (halt_sel % (wb_c + 1));
    rw_cnt = 0; rw_at = -1; ms_cnt = 0; ms_at = -1;

    k = 0;
    while (!imem_req && k < 20) begin @(negedge clock); k++; end
    check("fetch_req", 32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr, m_pc);

    halt_req = (halt_cyc == 0);
    repeat (imem_wait) begin
      imem_valid = 1'b0;
      @(negedge clock);
      halt_req = 1'b0;
      check("fetch_hold", 32'(imem_req), 32'd1);
    end
    imem_valid = 1'b1;
    imem_rdata = word;
    @(negedge clock);
    halt_req   = 1'b0;
    imem_valid = 1'b0;

    c = 1;
    while (c < 40) begin
      if (c >= 2 && (imem_req || !busy)) break;
      if (regwrite_control) begin rw_cnt++; rw_at = c; end
      if (mul_start) begin ms_cnt++; ms_at = c; end
      check("rw_ms_excl", 32'(regwrite_control & mul_start), 32'd0);
      if (legal && c == wb_c) begin
        check("alu_control", 32'(alu_control), 32'(alu));
        check("rs1", 32'(rs1_addr), 32'(word[19:15]));
        check("rs2", 32'(rs2_addr), 32'(word[24:20]));
        check("rd", 32'(rd_addr), 32'(word[11:7]));
      end
      halt_req   = (c == halt_cyc);
      start      = (c == 1) ? spur : 1'b0;
      imem_valid = spur && ($urandom % 3 == 0);
      imem_rdata = $urandom;
      if (is_mul) mul_done = (c == 2) ? spur : (c == 2 + mul_wait);
      else        mul_done = spur && ($urandom % 2 == 0);
      @(negedge clock);
      c++;
    end
    imem_valid = 1'b0; mul_done = 1'b0; halt_req = 1'b0; start = 1'b0;

    if (!legal) begin
      check("trap_lat", 32'(c), 32'd2);
      check("trap_flag", 32'(illegal_instr), 32'd1);
      check("trap_busy", 32'(busy), 32'd0);
      check("trap_req", 32'(imem_req), 32'd0);
      check("trap_pc", imem_addr, m_pc);
      check("trap_rw", 32'(rw_cnt), 32'd0);
      check("trap_ms", 32'(ms_cnt), 32'd0);
      check("trap_ret", retired_count, m_retired);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      m_pc = 32'd0;
      check("trap_clear", 32'(illegal_instr), 32'd0);
      check("trap_refetch", imem_addr, m_pc);
      check("trap_refetch_req", 32'(imem_req), 32'd1);
    end else begin
      halted = (halt_cyc >= 0);
      m_retired = m_retired + 32'd1;
      m_pc      = m_pc + 32'd4;
      check("latency", 32'(c), 32'(wb_c + 1));
      check("rw_count", 32'(rw_cnt), (word[11:7] != 5'd0) ? 32'd1 : 32'd0);
      if (word[11:7] != 5'd0) check("rw_cycle", 32'(rw_at), 32'(wb_c));
      check("ms_count", 32'(ms_cnt), is_mul ? 32'd1 : 32'd0);
      if (is_mul) check("ms_cycle", 32'(ms_at), 32'd2);
      check("retired", retired_count, m_retired);
      check("next_pc", imem_addr, m_pc);
      check("halt_idle", 32'(busy), halted ? 32'd0 : 32'd1);
      check("next_req", 32'(imem_req), halted ? 32'd0 : 32'd1);
      if (halted) begin
        halt_req = 1'b1;
        @(negedge clock);
        halt_req = 1'b0;
        check("idle_stays", 32'(busy), 32'd0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        m_pc = 32'd0;
        check("restart_addr", imem_addr, m_pc);
        check("restart_keeps_count", retired_count, m_retired);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int sel;
    logic [4:0] r1, r2, rd;
    ops[0] = '{3'd0, 7'd0,  4'b0010};
    ops[1] = '{3'd0, 7'd32, 4'b0100};
    ops[2] = '{3'd1, 7'd0,  4'b0011};
    ops[3] = '{3'd2, 7'd0,  4'b0110};
    ops[4] = '{3'd4, 7'd0,  4'b0111};
    ops[5] = '{3'd5, 7'd0,  4'b0101};
    ops[6] = '{3'd6, 7'd0,  4'b0001};
    ops[7] = '{3'd7, 7'd0,  4'b0000};

    reset = 1'b1; start = 1'b0; halt_req = 1'b0; imem_valid = 1'b0;
    imem_rdata = 32'd0; mul_done = 1'b0;
    m_pc = 32'd0; m_retired = 32'd0;
    repeat (2) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_ret", retired_count, 32'd0);
    check("rst_ill", 32'(illegal_instr), 32'd0);
    check("rst_rw", 32'(regwrite_control), 32'd0);
    check("rst_alu", 32'(alu_control), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;

    repeat (3) run_instr(32'h002081B3, 0, 0, -1, 1'b0);
    run_instr(32'h40208133, 0, 0, -1, 1'b0);
    run_instr(32'h0020C1B3, 0, 0, -1, 1'b0);
    run_instr(32'h0020A1B3, 0, 5, -1, 1'b0);
    run_instr(32'h0020B1B3, 0, 0, -1, 1'b0);
    run_instr(32'h4020D1B3, 1, 0, -1, 1'b0);
    run_instr(32'h002081B3, 0, 0, 1, 1'b0);
    run_instr(32'h00208033, 0, 0, -1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom % 10);
      r1 = 5'($urandom);
      r2 = 5'($urandom);
      rd = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
      if (sel < 8)
        w = {ops[sel].f7, r2, r1, ops[sel].f3, rd, 7'h33};
      else if (sel == 8)
        w = {7'h20, r2, r1, 3'($urandom), rd, 7'h33};
      else
        w = $urandom;
      run_instr(w, int'($urandom % 3), 1 + int'($urandom % 4),
                ($urandom % 6 == 0) ? int'($urandom % 16) : -1,
                1'($urandom));
    end

    // Reset while stalled on the multiplier.
    imem_valid = 1'b1;
    imem_rdata = 32'h0020A1B3;
    @(negedge clock);
    imem_valid = 1'b0;
    @(negedge clock);
    check("rst_mid_ms", 32'(mul_start), 32'd1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_req", 32'(imem_req), 32'd0);
    check("async_ms", 32'(mul_start), 32'd0);
    check("async_rw", 32'(regwrite_control), 32'd0);
    check("async_ret", retired_count, 32'd0);
    check("async_addr", imem_addr, 32'd0);
    check("async_alu", 32'(alu_control), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    mul_done = 1'b1;
    @(negedge clock);
    mul_done = 1'b0;
    repeat (3) begin
      check("late_done_rw", 32'(regwrite_control), 32'd0);
      check("late_done_busy", 32'(busy), 32'd0);
      @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
